// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer geometry, pixel type and rect-fill FSM encoding.
// vga_ctrl, vmem and the fill/blit engines all take their dimensions from here.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int XW       = 10;
  localparam int YW       = 9;
  localparam int DW       = 24;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [XW-1:0] xcoord_t;
  typedef logic [YW-1:0] ycoord_t;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    FILL,
    DONE
  } fill_state_e;

  function automatic xcoord_t clamp_x(input xcoord_t v);
    return (v > xcoord_t'(H_ACTIVE - 1)) ? xcoord_t'(H_ACTIVE - 1) : v;
  endfunction

  function automatic ycoord_t clamp_y(input ycoord_t v);
    return (v > ycoord_t'(V_ACTIVE - 1)) ? ycoord_t'(V_ACTIVE - 1) : v;
  endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// Command channel, vblank input and vmem write port of the rectangle-fill engine.
// master = command source / observer side, slave = the engine itself.
interface vga_rect_fill_if;
  import vga_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  xcoord_t              cmd_x0;
  ycoord_t              cmd_y0;
  xcoord_t              cmd_x1;
  ycoord_t              cmd_y1;
  pixel_t               cmd_color;
  logic                 vblank;
  logic                 busy;
  logic                 done;
  logic                 wr_en;
  logic [XW+YW-1:0]     wr_addr;
  pixel_t               wr_data;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, vblank,
    input  cmd_ready, busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, vblank,
    output cmd_ready, busy, done, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/vga_xy_scan.sv
// Raster x/y counter over a loaded [xl..xh]x[yl..yh] window; x inner, y outer.
// Counters move only while en=1; last flags the (xh,yh) position.
module vga_xy_scan
  import vga_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    en,
  input  xcoord_t xl,
  input  xcoord_t xh,
  input  ycoord_t yl,
  input  ycoord_t yh,
  output xcoord_t x,
  output ycoord_t y,
  output logic    last
);

  xcoord_t x_q, x_d;
  ycoord_t y_q, y_d;
  xcoord_t xl_q, xl_d;
  xcoord_t xh_q, xh_d;
  ycoord_t yh_q, yh_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    xl_d = xl_q;
    xh_d = xh_q;
    yh_d = yh_q;
    if (load) begin
      x_d  = xl;
      y_d  = yl;
      xl_d = xl;
      xh_d = xh;
      yh_d = yh;
    end else if (en) begin
      if (x_q == xh_q) begin
        x_d = xl_q;
        // y stays parked at yh after the final pixel
        if (y_q != yh_q) begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      xl_q <= '0;
      xh_q <= '0;
      yh_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      xl_q <= xl_d;
      xh_q <= xh_d;
      yh_q <= yh_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xh_q) && (y_q == yh_q);

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill into vmem: accept at T, normalise/clamp at T+1, one write per cycle from T+2.
// cmd_ready only in IDLE; with VBLANK_ONLY=1 writes stall (counters hold) while vblank=0.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter bit VBLANK_ONLY = 1'b0
) (
  input logic            clk,
  input logic            rst,
  vga_rect_fill_if.slave bus
);

  fill_state_e state_q, state_d;
  xcoord_t     x0_q, x0_d, x1_q, x1_d;
  ycoord_t     y0_q, y0_d, y1_q, y1_d;
  pixel_t      color_q, color_d;

  logic    cmd_ready;
  logic    go;
  logic    scan_load;
  logic    scan_en;
  logic    scan_last;
  xcoord_t scan_x, xl_n, xh_n;
  ycoord_t scan_y, yl_n, yh_n;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign go        = !VBLANK_ONLY || bus.vblank;

  // Normalise corner order, then clamp both ends into the visible area
  assign xl_n = clamp_x((x0_q < x1_q) ? x0_q : x1_q);
  assign xh_n = clamp_x((x0_q < x1_q) ? x1_q : x0_q);
  assign yl_n = clamp_y((y0_q < y1_q) ? y0_q : y1_q);
  assign yh_n = clamp_y((y0_q < y1_q) ? y1_q : y0_q);

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    color_d   = color_q;
    scan_load = 1'b0;
    scan_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          x0_d    = bus.cmd_x0;
          y0_d    = bus.cmd_y0;
          x1_d    = bus.cmd_x1;
          y1_d    = bus.cmd_y1;
          color_d = bus.cmd_color;
          state_d = LATCH;
        end
      end
      LATCH: begin
        scan_load = 1'b1;
        state_d   = FILL;
      end
      FILL: begin
        scan_en = go;
        if (go && scan_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
    end
  end

  vga_xy_scan u_scan (
    .clk  (clk),
    .rst  (rst),
    .load (scan_load),
    .en   (scan_en),
    .xl   (xl_n),
    .xh   (xh_n),
    .yl   (yl_n),
    .yh   (yh_n),
    .x    (scan_x),
    .y    (scan_y),
    .last (scan_last)
  );

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = ((state_q == LATCH) || (state_q == FILL)) && !rst;
  assign bus.done      = (state_q == DONE) && !rst;
  assign bus.wr_en     = (state_q == FILL) && go && !rst;
  assign bus.wr_addr   = {scan_x, scan_y};
  assign bus.wr_data   = color_q;

endmodule
